// File: rtl/display_color_decoder.sv
// Recovers per-channel duty (0..255) from a 256-slot PWM drive stream, for `segments` panel segments in parallel.
// Outputs are registered: pixel/pixel_valid update one clock after the cycle-255 sample; there is no backpressure.
module display_color_decoder #(
    parameter int segments = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               cycle,
    input  logic [segments*3-1:0]    rgb,
    output logic [segments*24-1:0]   pixel,
    output logic                     pixel_valid,
    output logic                     frame_error,
    output logic                     locked
);

    localparam int CH = segments * 3;

    typedef enum logic {HUNT, ACCUM} state_t;

    state_t                  state_q, state_d;
    logic [CH-1:0][8:0]      acc_q, acc_d;
    logic [7:0]              exp_q, exp_d;
    logic [segments*24-1:0]  pixel_d;
    logic                    pv_d, fe_d;
    logic [8:0]              sum;

    // Channel i = s*3+c lands at pixel[i*8 +: 8], which matches the red/green/blue byte order.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        exp_d   = exp_q;
        pixel_d = pixel;
        pv_d    = 1'b0;
        fe_d    = 1'b0;
        sum     = '0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (cycle == 8'd0) begin
                        for (int i = 0; i < CH; i++) acc_d[i] = {8'd0, rgb[i]};
                        exp_d   = 8'd1;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (cycle != exp_q) begin
                        // Offending sample is dropped, even a cycle-0 one; a fresh cycle 0 is needed.
                        fe_d    = 1'b1;
                        acc_d   = '0;
                        exp_d   = 8'd0;
                        state_d = HUNT;
                    end else if (exp_q == 8'd0) begin
                        for (int i = 0; i < CH; i++) acc_d[i] = {8'd0, rgb[i]};
                        exp_d = 8'd1;
                    end else begin
                        for (int i = 0; i < CH; i++) begin
                            sum      = acc_q[i] + {8'd0, rgb[i]};
                            acc_d[i] = sum;
                            if (exp_q == 8'd255)
                                pixel_d[i*8 +: 8] = sum[8] ? 8'hff : sum[7:0];
                        end
                        pv_d  = (exp_q == 8'd255);
                        exp_d = exp_q + 8'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            acc_q       <= '0;
            exp_q       <= 8'd0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            exp_q       <= exp_d;
            pixel       <= pixel_d;
            pixel_valid <= pv_d;
            frame_error <= fe_d;
        end
    end

    assign locked = (state_q == ACCUM);

endmodule
